// File: rtl/dm_store_buffer.sv
// Store buffer in front of the data memory: queues stores from MEM, drains them
// one per cycle into the single write port, yields to loads and flags load hazards.
module dm_store_buffer #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_valid,
  input  logic [31:0]   push_pc,
  input  logic [31:0]   push_addr,
  input  logic [31:0]   push_data,
  input  logic [2:0]    push_mode,
  output logic          push_ready,
  input  logic          load_check,
  input  logic [31:0]   load_addr,
  output logic          load_hazard,
  output logic          dm_write_enable,
  output logic [31:0]   dm_write_addr,
  output logic [31:0]   dm_write_data,
  output logic [2:0]    dm_mode,
  output logic [31:0]   dm_curr_pc,
  input  logic          dm_invalid,
  output logic          error,
  output logic [31:0]   error_pc,
  output logic [CW-1:0] count,
  output logic          empty
);

  // Access mode codes shared with the data memory.
  localparam logic [2:0] DM_W  = 3'd0;
  localparam logic [2:0] DM_H  = 3'd1;
  localparam logic [2:0] DM_B  = 3'd2;
  localparam logic [2:0] DM_HU = 3'd3;
  localparam logic [2:0] DM_BU = 3'd4;

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]   r_pc   [DEPTH];
  logic [31:0]   r_addr [DEPTH];
  logic [31:0]   r_data [DEPTH];
  logic [2:0]    r_mode [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_error;
  logic [31:0]   r_error_pc;

  logic          w_empty;
  logic          w_ready;
  logic          w_mode_ok;
  logic          w_push;
  logic          w_bad_push;
  logic          w_pop;
  logic          w_hit;
  logic [PW-1:0] w_off [DEPTH];

  assign w_empty    = (r_count == '0);
  assign w_ready    = (r_count != CW'(DEPTH));
  assign w_mode_ok  = (push_mode == DM_W) || (push_mode == DM_H) || (push_mode == DM_B);
  assign w_push     = push_valid && w_ready && w_mode_ok;
  assign w_bad_push = push_valid && w_ready && !w_mode_ok;
  assign w_pop      = !w_empty && !load_check;

  // A slot is live when its distance from the head is below the count.
  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w_off[i] = PW'(i) - r_head;
      if ((CW'(w_off[i]) < r_count) && (r_addr[i][31:2] == load_addr[31:2]))
        w_hit = 1'b1;
    end
  end

  assign push_ready      = w_ready;
  assign empty           = w_empty;
  assign count           = r_count;
  assign load_hazard     = load_check && w_hit;
  assign dm_write_enable = w_pop;
  assign dm_write_addr   = w_empty ? 32'd0 : r_addr[r_head];
  assign dm_write_data   = w_empty ? 32'd0 : r_data[r_head];
  assign dm_mode         = w_empty ? 3'd0  : r_mode[r_head];
  assign dm_curr_pc      = w_empty ? 32'd0 : r_pc[r_head];
  assign error           = r_error;
  assign error_pc        = r_error_pc;

  // The head entry is older than the incoming push, so a drain fault takes priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_error    <= 1'b0;
      r_error_pc <= 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]   <= 32'd0;
        r_addr[i] <= 32'd0;
        r_data[i] <= 32'd0;
        r_mode[i] <= 3'd0;
      end
    end else begin
      if (w_push) begin
        r_pc[r_tail]   <= push_pc;
        r_addr[r_tail] <= push_addr;
        r_data[r_tail] <= push_data;
        r_mode[r_tail] <= push_mode;
        r_tail         <= r_tail + PW'(1);
      end
      if (w_pop)
        r_head <= r_head + PW'(1);
      if (w_push && !w_pop)
        r_count <= r_count + CW'(1);
      else if (!w_push && w_pop)
        r_count <= r_count - CW'(1);
      if (!r_error) begin
        if (w_pop && dm_invalid) begin
          r_error    <= 1'b1;
          r_error_pc <= r_pc[r_head];
        end else if (w_bad_push) begin
          r_error    <= 1'b1;
          r_error_pc <= push_pc;
        end
      end
    end
  end

endmodule

// File: tb/tb_dm_store_buffer.sv
// Directed bench for dm_store_buffer: a queue of expected drain entries is filled
// on accepted pushes and compared against the write port as entries pop.
module tb_dm_store_buffer;

  localparam int DEPTH = 4;
  localparam int CW    = 3;
  localparam logic [2:0] DM_W  = 3'd0;
  localparam logic [2:0] DM_H  = 3'd1;
  localparam logic [2:0] DM_B  = 3'd2;
  localparam logic [2:0] DM_HU = 3'd3;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  mode;
  } entry_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          push_valid;
  logic [31:0]   push_pc, push_addr, push_data;
  logic [2:0]    push_mode;
  logic          push_ready;
  logic          load_check;
  logic [31:0]   load_addr;
  logic          load_hazard;
  logic          dm_write_enable;
  logic [31:0]   dm_write_addr, dm_write_data, dm_curr_pc;
  logic [2:0]    dm_mode;
  logic          dm_invalid;
  logic          error;
  logic [31:0]   error_pc;
  logic [CW-1:0] count;
  logic          empty;

  entry_t      sb[$];
  logic        expErr;
  logic [31:0] expErrPc;
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  dm_store_buffer #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .reset(reset),
    .push_valid(push_valid), .push_pc(push_pc), .push_addr(push_addr),
    .push_data(push_data), .push_mode(push_mode), .push_ready(push_ready),
    .load_check(load_check), .load_addr(load_addr), .load_hazard(load_hazard),
    .dm_write_enable(dm_write_enable), .dm_write_addr(dm_write_addr),
    .dm_write_data(dm_write_data), .dm_mode(dm_mode), .dm_curr_pc(dm_curr_pc),
    .dm_invalid(dm_invalid), .error(error), .error_pc(error_pc),
    .count(count), .empty(empty)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic modelHazard();
    logic hit = 1'b0;
    foreach (sb[i]) if (sb[i].addr[31:2] == load_addr[31:2]) hit = 1'b1;
    return load_check && hit;
  endfunction

  // Checks every output against the model, then advances one clock and updates it.
  task automatic applyStimulus();
    logic expWen, expReady, modeOk;
    #1;
    expWen   = (sb.size() != 0) && !load_check;
    expReady = (sb.size() != DEPTH);
    modeOk   = (push_mode == DM_W) || (push_mode == DM_H) || (push_mode == DM_B);
    checkOutput("count", 32'(count), 32'(sb.size()));
    checkOutput("empty", 32'(empty), 32'(sb.size() == 0));
    checkOutput("push_ready", 32'(push_ready), 32'(expReady));
    checkOutput("write_enable", 32'(dm_write_enable), 32'(expWen));
    checkOutput("load_hazard", 32'(load_hazard), 32'(modelHazard()));
    checkOutput("error", 32'(error), 32'(expErr));
    checkOutput("error_pc", error_pc, expErrPc);
    if (sb.size() != 0) begin
      checkOutput("wr_addr", dm_write_addr, sb[0].addr);
      checkOutput("wr_data", dm_write_data, sb[0].data);
      checkOutput("wr_mode", 32'(dm_mode), 32'(sb[0].mode));
      checkOutput("wr_pc", dm_curr_pc, sb[0].pc);
    end else begin
      checkOutput("wr_addr_idle", dm_write_addr, 32'd0);
      checkOutput("wr_pc_idle", dm_curr_pc, 32'd0);
    end
    @(posedge clk);
    if (!expErr && expWen && dm_invalid) begin
      expErr   = 1'b1;
      expErrPc = sb[0].pc;
    end else if (!expErr && push_valid && expReady && !modeOk) begin
      expErr   = 1'b1;
      expErrPc = push_pc;
    end
    if (expWen) void'(sb.pop_front());
    if (push_valid && expReady && modeOk)
      sb.push_back('{pc: push_pc, addr: push_addr, data: push_data, mode: push_mode});
    @(negedge clk);
  endtask

  task automatic setPush(input logic v, input logic [31:0] pc, input logic [31:0] addr,
                         input logic [31:0] data, input logic [2:0] mode);
    push_valid = v;
    push_pc    = pc;
    push_addr  = addr;
    push_data  = data;
    push_mode  = mode;
  endtask

  initial begin
    expErr     = 1'b0;
    expErrPc   = 32'd0;
    reset      = 1'b1;
    load_check = 1'b0;
    load_addr  = 32'd0;
    dm_invalid = 1'b0;
    setPush(1'b0, 32'd0, 32'd0, 32'd0, DM_W);
    @(negedge clk);
    #1;
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_empty", 32'(empty), 32'd1);
    checkOutput("rst_ready", 32'(push_ready), 32'd1);
    checkOutput("rst_wen", 32'(dm_write_enable), 32'd0);
    checkOutput("rst_error", 32'(error), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus();

    // Single store then drain.
    setPush(1'b1, 32'h3000, 32'h10, 32'hDEAD_BEEF, DM_W);
    applyStimulus();
    setPush(1'b0, 32'd0, 32'd0, 32'd0, DM_W);
    applyStimulus();
    applyStimulus();

    // Fill with the port blocked; the fifth push must be refused.
    load_check = 1'b1;
    load_addr  = 32'h1000;
    for (int i = 0; i < 5; i++) begin
      setPush(1'b1, 32'h3100 + 32'(i * 4), 32'(i * 4), 32'h100 + 32'(i), DM_W);
      applyStimulus();
    end
    setPush(1'b0, 32'd0, 32'd0, 32'd0, DM_W);
    load_check = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus();
    // Four more pushes wrap the pointers while draining concurrently.
    for (int i = 0; i < 4; i++) begin
      setPush(1'b1, 32'h3200 + 32'(i * 4), 32'h40 + 32'(i * 4), 32'h200 + 32'(i), DM_H);
      applyStimulus();
    end
    setPush(1'b0, 32'd0, 32'd0, 32'd0, DM_W);
    for (int i = 0; i < 3; i++) applyStimulus();

    // Word-granular load hazard against a pending byte store.
    setPush(1'b1, 32'h3300, 32'h23, 32'hAB, DM_B);
    applyStimulus();
    setPush(1'b0, 32'd0, 32'd0, 32'd0, DM_W);
    load_check = 1'b1;
    load_addr  = 32'h20;
    applyStimulus();
    load_addr  = 32'h24;
    applyStimulus();
    // Stalled load drops load_check until the hazard would clear.
    load_addr = 32'h20;
    for (int i = 0; i < 8; i++) begin
      load_check = 1'b1;
      #1;
      if (!modelHazard()) break;
      applyStimulus();
      load_check = 1'b0;
      applyStimulus();
    end
    load_check = 1'b1;
    applyStimulus();
    checkOutput("hazard_after_drain", 32'(sb.size()), 32'd0);

    // Port yield: two entries held for three cycles, then push and pop together.
    for (int i = 0; i < 2; i++) begin
      setPush(1'b1, 32'h3400 + 32'(i * 4), 32'h80 + 32'(i * 4), 32'h300 + 32'(i), DM_W);
      applyStimulus();
    end
    setPush(1'b0, 32'd0, 32'd0, 32'd0, DM_W);
    for (int i = 0; i < 3; i++) applyStimulus();
    load_check = 1'b0;
    setPush(1'b1, 32'h3410, 32'h90, 32'h310, DM_W);
    applyStimulus();
    setPush(1'b0, 32'd0, 32'd0, 32'd0, DM_W);
    for (int i = 0; i < 3; i++) applyStimulus();

    // Faults: bad mode first, then an invalid drain; the first fault is kept.
    setPush(1'b1, 32'h3004, 32'h60, 32'h1, DM_HU);
    applyStimulus();
    setPush(1'b1, 32'h3008, 32'h64, 32'h2, DM_W);
    applyStimulus();
    setPush(1'b0, 32'd0, 32'd0, 32'd0, DM_W);
    dm_invalid = 1'b1;
    applyStimulus();
    dm_invalid = 1'b0;
    applyStimulus();
    checkOutput("fault_epc", error_pc, 32'h3004);

    // Async reset between edges with three entries pending.
    load_check = 1'b1;
    load_addr  = 32'h1000;
    for (int i = 0; i < 3; i++) begin
      setPush(1'b1, 32'h3500 + 32'(i * 4), 32'hA0 + 32'(i * 4), 32'h400 + 32'(i), DM_W);
      applyStimulus();
    end
    setPush(1'b0, 32'd0, 32'd0, 32'd0, DM_W);
    load_check = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("arst_count", 32'(count), 32'd0);
    checkOutput("arst_empty", 32'(empty), 32'd1);
    checkOutput("arst_wen", 32'(dm_write_enable), 32'd0);
    checkOutput("arst_error", 32'(error), 32'd0);
    sb.delete();
    expErr   = 1'b0;
    expErrPc = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    applyStimulus();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dm_store_buffer.md
# dm_store_buffer

Store buffer that sits directly upstream of the data memory. It queues store requests from the MEM stage and drains them into the memory's single write port one per cycle. It yields the port to loads and raises a hazard when a load targets a word that still has a pending store. The buffer lets stores retire from the pipeline without waiting for the memory port, and keeps loads from reading stale words.

## Interface
Parameters:
- `DEPTH`, default 4: number of entries; power of two, 2..16.
- `CW`, default log2(DEPTH)+1: width of `count`.

Ports:
- `clk` in 1: the single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `push_valid` in 1: MEM stage presents a store this cycle.
- `push_pc` in 32: PC of the store instruction.
- `push_addr` in 32: byte address of the store.
- `push_data` in 32: store data, right-aligned for H/B.
- `push_mode` in 3: access mode, dm.h codes.
- `push_ready` out 1: buffer can accept a store this cycle.
- `load_check` in 1: MEM stage is performing a load this cycle.
- `load_addr` in 32: byte address of that load.
- `load_hazard` out 1: the load must stall.
- `dm_write_enable` out 1: write strobe to the data memory.
- `dm_write_addr` out 32, `dm_write_data` out 32, `dm_mode` out 3, `dm_curr_pc` out 32: fields of the head entry.
- `dm_invalid` in 1: data memory's invalid flag for the current access.
- `error` out 1: sticky fault flag.
- `error_pc` out 32: PC of the first faulting store.
- `count` out CW: number of valid entries.
- `empty` out 1: `count == 0`.

## Operation
- Circular FIFO with head and tail pointers and a count. Each entry holds {pc, addr, data, mode}.
- Push:
  - Accepted when `push_valid && push_ready` and `push_mode` is DM_W, DM_H or DM_B. The entry is written at the tail and the tail increments, wrapping modulo `DEPTH`.
  - A push with any other mode is not enqueued. It sets `error` and captures `push_pc` in `error_pc` if `error` was 0.
  - `push_valid` while not ready is ignored. The upstream stage must hold the request.
- `push_ready = (count != DEPTH)`. There is no same-cycle bypass when full, even if a pop occurs that cycle.
- Drain:
  - `dm_write_enable = !empty && !load_check`. The data memory selects its operating address from the write address whenever a write is enabled, so a load always wins the port.
  - `dm_write_addr`, `dm_write_data`, `dm_mode` and `dm_curr_pc` show the head entry combinationally, and 0 when empty.
  - On each edge with `dm_write_enable` high, the head pops and increments with wrap.
  - If `dm_invalid` is high that cycle, the entry still pops. `error` sets and `error_pc` takes the head pc if `error` was 0.
- Hazard:
  - `load_hazard = load_check && (any valid entry has addr[31:2] == load_addr[31:2])`.
  - The comparison is word-granular regardless of mode or byte offset. Invalid slots never match.
- Simultaneous push and pop: both take effect and `count` is unchanged. When empty, a push is not drained in the same cycle.
- `error` and `error_pc` clear only on reset. First fault wins.

## Timing
- Reset values:
  - `count` 0, `empty` 1, `push_ready` 1.
  - `dm_write_enable` 0, `load_hazard` 0.
  - `dm_write_addr`, `dm_write_data`, `dm_mode` and `dm_curr_pc` all 0.
  - `error` 0, `error_pc` 0.
  - Pointers 0 and entry storage cleared.
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- Latency: a store pushed at edge N can be written to memory at edge N+1 at the earliest.
- Drain throughput is one entry per cycle while `load_check` is low.
- `load_hazard`, `push_ready`, `empty` and the `dm_*` outputs are combinational from state and current inputs. All state changes at the rising edge.
- A load stalled by `load_hazard` keeps `load_check` high, which blocks draining. Deadlock is avoided because the pipeline releases `load_check` while stalled; the hazard is recomputed once it is reasserted.
  - Requirement on the pipeline: a stalled load drops `load_check` until `load_hazard` would clear.
  - Requirement on the bench: the bench models exactly this.

## Test plan
- Single store, then drain:
  - Stimulus: push W, addr 0x0000_0010, data 0xDEAD_BEEF, pc 0x0000_3000.
  - Response: next cycle `dm_write_enable`=1 with those fields; `count` 1→0; `empty`=1 after.
- Fill and wrap:
  - Stimulus: with `load_check`=1, push 5 stores.
  - Response: `push_ready`=0 after 4 and the 5th is ignored. After release, the 4 stores drain in order addr 0x0,0x4,0x8,0xC. Then 4 more pushes wrap the pointers and drain correctly.
- Load hazard:
  - Stimulus: pending B store at 0x0000_0023; load at 0x0000_0020.
  - Response: `load_hazard`=1. A load at 0x0000_0024 gives `load_hazard`=0. After drain, a load at 0x20 gives `load_hazard`=0.
- Port yield and simultaneous events:
  - Stimulus: count=2 with `load_check`=1 for 3 cycles, then push and pop in the same cycle.
  - Response: no write while `load_check` is high; `count` holds at 2 through the simultaneous push/pop.
- Faults:
  - Stimulus: push mode DM_HU, pc 0x3004; then a W store whose drain sees `dm_invalid`=1, pc 0x3008.
  - Response: `error`=1, `error_pc`=0x3004 (first fault kept); the faulting entry still pops.
- Async reset:
  - Stimulus: assert `reset` between edges with 3 entries pending.
  - Response: immediately `count` 0, `empty` 1, `dm_write_enable` 0, `error` 0.
